// File: rtl/mem_read_data_decoder.sv
// -----------------------------------------------------------------------------
// mem_read_data_decoder
//
// Load-side data formatter. Load descriptors (byte offset, access size,
// signedness, destination tag) are queued when the load issues. Raw 32-bit
// memory words are matched to descriptors in strict FIFO order as they
// return. The addressed byte or halfword is extracted using the big-endian
// lane map shared with the store encoder, and is then zero- or sign-extended.
//
// Optional feature macro: MEM_READ_DEC_ALIGN_CHECK_EN
//   defined   : misaligned or reserved accesses are flagged on ld_err and
//               return zero data (the memory response is still consumed).
//   undefined : ld_err is always 0 and addresses are forced into alignment
//               (half uses offset[1], word ignores offset, size 3 = word).
//
// Parameters
//   DEPTH  descriptor queue entries (power of 2, >= 2)
//   TAGW   destination-register tag width
//
// Ports
//   clk         in   1     rising-edge clock
//   rst_n       in   1     asynchronous active-low reset
//   req_valid   in   1     load issued this cycle
//   req_ready   out  1     descriptor queue can accept
//   req_offset  in   2     byte address [1:0]
//   req_size    in   2     0=word 1=half 2=byte 3=reserved
//   req_signed  in   1     1=sign-extend, 0=zero-extend
//   req_tag     in   TAGW  destination register
//   mem_rvalid  in   1     memory read data valid
//   mem_rdata   in   32    raw memory word
//   ld_valid    out  1     decoded result valid (one-cycle pulse)
//   ld_data     out  32    extended load result
//   ld_tag      out  TAGW  tag of the popped descriptor
//   ld_err      out  1     misaligned / reserved access
//   proto_err   out  1     sticky: response arrived with queue empty
// -----------------------------------------------------------------------------
module mem_read_data_decoder #(
  parameter int DEPTH = 2,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_offset,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [TAGW-1:0] req_tag,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            ld_valid,
  output logic [31:0]     ld_data,
  output logic [TAGW-1:0] ld_tag,
  output logic            ld_err,
  output logic            proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // Extract the addressed field (big-endian lanes) and extend it.
  // Size 3 decodes as a word; when alignment checking is enabled such
  // requests never reach here with their data used.
  function automatic logic [31:0] f_extract(
    input logic [31:0] d,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    // Only offset[1] selects the half, which also forces alignment.
    h = off[1] ? d[15:0] : d[31:16];
    case (size)
      2'd1:    r = {{16{sgn & h[15]}}, h};
      2'd2:    r = {{24{sgn & b[7]}}, b};
      default: r = d;
    endcase
    return r;
  endfunction

  // Misaligned word/half or reserved size.
  function automatic logic f_misaligned(
    input logic [1:0] off,
    input logic [1:0] size
  );
    logic e;
    case (size)
      2'd0:    e = (off != 2'd0);
      2'd1:    e = off[0];
      2'd2:    e = 1'b0;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  logic [1:0]      r_q_off  [DEPTH];
  logic [1:0]      r_q_size [DEPTH];
  logic            r_q_sgn  [DEPTH];
  logic [TAGW-1:0] r_q_tag  [DEPTH];
`ifdef MEM_READ_DEC_ALIGN_CHECK_EN
  logic            r_q_err  [DEPTH];
`endif

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_ld_valid;
  logic [31:0]     r_ld_data;
  logic [TAGW-1:0] r_ld_tag;
  logic            r_ld_err;
  logic            r_proto_err;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_dec;

  // Ready is computed from the registered count, before any same-cycle pop.
  assign req_ready = (r_count < CNT_DEPTH);
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_push    = req_valid && req_ready;
  assign w_pop     = mem_rvalid && !w_empty;
  assign w_dec     = f_extract(mem_rdata, r_q_off[r_rd_ptr], r_q_size[r_rd_ptr],
                               r_q_sgn[r_rd_ptr]);

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Descriptor storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_off[i]  <= 2'd0;
        r_q_size[i] <= 2'd0;
        r_q_sgn[i]  <= 1'b0;
        r_q_tag[i]  <= {TAGW{1'b0}};
`ifdef MEM_READ_DEC_ALIGN_CHECK_EN
        r_q_err[i]  <= 1'b0;
`endif
      end
    end else if (w_push) begin
      r_q_off[r_wr_ptr]  <= req_offset;
      r_q_size[r_wr_ptr] <= req_size;
      r_q_sgn[r_wr_ptr]  <= req_signed;
      r_q_tag[r_wr_ptr]  <= req_tag;
`ifdef MEM_READ_DEC_ALIGN_CHECK_EN
      r_q_err[r_wr_ptr]  <= f_misaligned(req_offset, req_size);
`endif
    end
  end

  // Registered load result; data/tag hold between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_valid <= 1'b0;
      r_ld_data  <= 32'd0;
      r_ld_tag   <= {TAGW{1'b0}};
      r_ld_err   <= 1'b0;
    end else begin
      r_ld_valid <= w_pop;
      if (w_pop) begin
        r_ld_tag <= r_q_tag[r_rd_ptr];
`ifdef MEM_READ_DEC_ALIGN_CHECK_EN
        if (r_q_err[r_rd_ptr]) begin
          r_ld_data <= 32'd0;
          r_ld_err  <= 1'b1;
        end else begin
          r_ld_data <= w_dec;
          r_ld_err  <= 1'b0;
        end
`else
        r_ld_data <= w_dec;
        r_ld_err  <= 1'b0;
`endif
      end
    end
  end

  // Sticky protocol error: response with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (mem_rvalid && w_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  assign ld_valid  = r_ld_valid;
  assign ld_data   = r_ld_data;
  assign ld_tag    = r_ld_tag;
  assign ld_err    = r_ld_err;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_read_data_decoder.sv
module tb_mem_read_data_decoder;

  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_offset;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [TAGW-1:0] req_tag;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic [TAGW-1:0] ld_tag;
  logic            ld_err;
  logic            proto_err;

  typedef struct {
    logic [31:0]     d;
    logic [TAGW-1:0] t;
    logic            e;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  mem_read_data_decoder #(.DEPTH(2), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_tag    (req_tag),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_tag     (ld_tag),
    .ld_err     (ld_err),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ld_valid pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (ld_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ld_valid: got tag %0d data %h expected no result", ld_tag, ld_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ld_data", ld_data, e.d);
        chk("ld_tag", 32'(ld_tag), 32'(e.t));
        chk("ld_err", 32'(ld_err), 32'(e.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] off, input logic [1:0] sz,
                         input logic sg, input logic [TAGW-1:0] tg);
    req_valid  = v;
    req_offset = off;
    req_size   = sz;
    req_signed = sg;
    req_tag    = tg;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic [TAGW-1:0] exp_t_, input logic exp_e);
    exp_t e;
    mem_rvalid = v;
    mem_rdata  = d;
    if (v) begin
      e.d = exp_d;
      e.t = exp_t_;
      e.e = exp_e;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle state
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_tag", 32'(ld_tag), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // Signed byte at offset 1
    set_req(1'b1, 2'd1, 2'd2, 1'b1, 5'd7);
    tick();
    idle();
    set_rsp(1'b1, 32'h12F45678, 32'hFFFFFFF4, 5'd7, 1'b0);
    tick();
    idle();
    tick();
    // Pulse has ended; data and tag hold
    chk("pulse_end_valid", 32'(ld_valid), 32'd0);
    chk("hold_ld_data", ld_data, 32'hFFFFFFF4);
    chk("hold_ld_tag", 32'(ld_tag), 32'd7);

    // Unsigned half at offset 2, then signed word at offset 0
    set_req(1'b1, 2'd2, 2'd1, 1'b0, 5'd3);
    tick();
    set_req(1'b1, 2'd0, 2'd0, 1'b1, 5'd4);
    set_rsp(1'b1, 32'hAAAA8001, 32'h00008001, 5'd3, 1'b0);
    tick();
    idle();
    set_rsp(1'b1, 32'hAAAA8001, 32'hAAAA8001, 5'd4, 1'b0);
    tick();
    idle();
    tick();

    // Fill the queue, then try an extra request that must be ignored
    set_req(1'b1, 2'd3, 2'd2, 1'b0, 5'd1);
    tick();
    set_req(1'b1, 2'd3, 2'd2, 1'b0, 5'd2);
    tick();
    chk("full_req_ready", 32'(req_ready), 32'd0);
    set_req(1'b1, 2'd0, 2'd0, 1'b0, 5'd9);
    tick();
    idle();
    set_rsp(1'b1, 32'h11223344, 32'h00000044, 5'd1, 1'b0);
    tick();
    set_rsp(1'b1, 32'h55667788, 32'h00000088, 5'd2, 1'b0);
    tick();
    idle();
    tick();
    chk("drained_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Simultaneous push and pop at count 1
    set_req(1'b1, 2'd0, 2'd1, 1'b1, 5'd10);
    tick();
    set_req(1'b1, 2'd0, 2'd2, 1'b1, 5'd11);
    set_rsp(1'b1, 32'h80017FFF, 32'hFFFF8001, 5'd10, 1'b0);
    tick();
    idle();
    chk("simul_count1_ready", 32'(req_ready), 32'd1);
    set_req(1'b1, 2'd2, 2'd2, 1'b0, 5'd12);
    tick();
    idle();
    chk("simul_then_full", 32'(req_ready), 32'd0);
    set_rsp(1'b1, 32'h80017FFF, 32'hFFFFFF80, 5'd11, 1'b0);
    tick();
    set_rsp(1'b1, 32'h80017FFF, 32'h0000007F, 5'd12, 1'b0);
    tick();
    idle();
    tick();

    // Misaligned half (offset 1), reserved size, misaligned word
`ifdef MEM_READ_DEC_ALIGN_CHECK_EN
    set_req(1'b1, 2'd1, 2'd1, 1'b1, 5'd5);
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'h00000000, 5'd5, 1'b1);
    tick();
    set_req(1'b1, 2'd0, 2'd3, 1'b0, 5'd6);
    mem_rvalid = 1'b0;
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'h00000000, 5'd6, 1'b1);
    tick();
    set_req(1'b1, 2'd2, 2'd0, 1'b0, 5'd8);
    mem_rvalid = 1'b0;
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'h00000000, 5'd8, 1'b1);
    tick();
`else
    set_req(1'b1, 2'd1, 2'd1, 1'b1, 5'd5);
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'hFFFFA1B2, 5'd5, 1'b0);
    tick();
    set_req(1'b1, 2'd0, 2'd3, 1'b0, 5'd6);
    mem_rvalid = 1'b0;
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'hA1B2C3D4, 5'd6, 1'b0);
    tick();
    set_req(1'b1, 2'd2, 2'd0, 1'b0, 5'd8);
    mem_rvalid = 1'b0;
    tick();
    idle();
    set_rsp(1'b1, 32'hA1B2C3D4, 32'hA1B2C3D4, 5'd8, 1'b0);
    tick();
`endif
    idle();
    tick();
    chk("no_proto_err_yet", 32'(proto_err), 32'd0);

    // Reset with a descriptor pending: it is discarded
    set_req(1'b1, 2'd0, 2'd2, 1'b0, 5'd13);
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ld_data", ld_data, 32'd0);
    chk("mid_rst_ld_tag", 32'(ld_tag), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_proto", 32'(proto_err), 32'd0);
    // Response with empty queue: proto_err, no ld_valid (monitor flags any)
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("proto_err_set", 32'(proto_err), 32'd1);
    chk("proto_no_valid", 32'(ld_valid), 32'd0);
    repeat (2) tick();
    chk("proto_err_sticky", 32'(proto_err), 32'd1);

    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
